// File: rtl/branch_resolve.sv
// Execute-stage branch resolution: compares the resolved direction/target with the
// fetch-time prediction, drives flush/redirect to fetch and owns the 2-bit BHT.
module branch_resolve #(
  parameter int RegWidth   = 32,
  parameter int BhtEntries = 64,
  parameter int BhtIdxW    = $clog2(BhtEntries)
) (
  input  logic                iClk,
  input  logic                iRst_n,
  input  logic                iExValid,
  input  logic                iExIsBranch,
  input  logic                iExIsJump,
  input  logic                iExBrTrue,
  input  logic [RegWidth-1:0] iExPc,
  input  logic [RegWidth-1:0] iExTarget,
  input  logic                iExPredTaken,
  input  logic [RegWidth-1:0] iExPredTarget,
  output logic                oExStall,
  output logic                oFlush,
  output logic                oRedirValid,
  input  logic                iRedirReady,
  output logic [RegWidth-1:0] oRedirPc,
  input  logic [RegWidth-1:0] iFetchPc,
  output logic                oFetchPredTaken,
  output logic [31:0]         oMispredCnt
);

  typedef enum logic {
    IDLE,
    REDIRECT
  } state_t;

  state_t state;

  logic [1:0]          bht [BhtEntries];
  logic                taken;
  logic [RegWidth-1:0] actual_pc;
  logic                mispred;
  logic                bht_upd;
  logic [BhtIdxW-1:0]  ex_idx;
  logic [BhtIdxW-1:0]  fetch_idx;
  logic                unused_pc_bits;

  assign ex_idx    = iExPc[BhtIdxW+1:2];
  assign fetch_idx = iFetchPc[BhtIdxW+1:2];

  // Only the index bits of the fetch PC select a counter; the rest are don't-care.
  assign unused_pc_bits = ^{iFetchPc[RegWidth-1:BhtIdxW+2], iFetchPc[1:0]};

  always_comb begin
    taken     = iExIsJump | (iExIsBranch & iExBrTrue);
    actual_pc = taken ? iExTarget : iExPc + RegWidth'(4);
    mispred   = (state == IDLE) & iExValid &
                ((taken != iExPredTaken) | (taken & (iExPredTarget != iExTarget)));
    bht_upd   = (state == IDLE) & iExValid & iExIsBranch & ~iExIsJump;
  end

  // Read returns the pre-update counter on a same-cycle index collision.
  assign oFetchPredTaken = bht[fetch_idx][1];

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      for (int unsigned i = 0; i < BhtEntries; i++) begin
        bht[i] <= 2'b01;
      end
    end else if (bht_upd) begin
      if (taken) begin
        if (bht[ex_idx] != 2'b11) bht[ex_idx] <= bht[ex_idx] + 2'b01;
      end else begin
        if (bht[ex_idx] != 2'b00) bht[ex_idx] <= bht[ex_idx] - 2'b01;
      end
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state       <= IDLE;
      oExStall    <= 1'b0;
      oFlush      <= 1'b0;
      oRedirValid <= 1'b0;
      oRedirPc    <= '0;
      oMispredCnt <= '0;
    end else begin
      oFlush <= 1'b0;
      case (state)
        IDLE: begin
          if (mispred) begin
            state       <= REDIRECT;
            oRedirPc    <= actual_pc;
            oRedirValid <= 1'b1;
            oFlush      <= 1'b1;
            oExStall    <= 1'b1;
            oMispredCnt <= oMispredCnt + 32'd1;
          end
        end
        REDIRECT: begin
          if (iRedirReady) begin
            state       <= IDLE;
            oRedirValid <= 1'b0;
            oExStall    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Execute-stage branch resolution and fetch redirect unit, directly downstream of the branch-condition evaluator.
- Consumes the taken/not-taken condition bit plus the branch PC/target and compares the result against the fetch-time prediction.
- On mismatch, issues a one-cycle front-end flush and a held redirect handshake to fetch.
- Owns the 2-bit branch history table (BHT) read by fetch, and a mispredict performance counter.

Parameters:
RegWidth, 32, datapath/PC width (rv32_isa value)
BhtEntries, 64, number of 2-bit counters; power of two, >= 2
BhtIdxW, $clog2(BhtEntries), BHT index width; index = PC[BhtIdxW+1:2]

Ports:
iClk  in  1  clock, rising edge
iRst_n  in  1  asynchronous active-low reset
iExValid  in  1  execute-stage control-flow instruction valid this cycle
iExIsBranch  in  1  conditional branch (B-type)
iExIsJump  in  1  unconditional JAL/JALR
iExBrTrue  in  1  branch condition result from the condition evaluator
iExPc  in  RegWidth  PC of the resolving instruction
iExTarget  in  RegWidth  computed taken target
iExPredTaken  in  1  fetch-time predicted direction carried down the pipe
iExPredTarget  in  RegWidth  fetch-time predicted target
oExStall  out  1  hold execute and upstream stages
oFlush  out  1  squash IF/ID contents, single-cycle pulse
oRedirValid  out  1  redirect request to fetch
iRedirReady  in  1  fetch accepts redirect
oRedirPc  out  RegWidth  corrected next PC
iFetchPc  in  RegWidth  fetch PC for prediction lookup
oFetchPredTaken  out  1  BHT prediction for iFetchPc
oMispredCnt  out  32  mispredict performance counter

Behaviour:
- Reset: iRst_n low asynchronously forces state IDLE; oExStall, oFlush, oRedirValid = 0; oRedirPc = 0; oMispredCnt = 0; every BHT counter = 2'b01 (weakly not-taken). Reset asserted mid-redirect abandons the redirect with no partial handshake.
- Resolution (combinational, IDLE only):
  - taken = iExIsJump | (iExIsBranch & iExBrTrue)
  - actual = taken ? iExTarget : iExPc + 4, computed modulo 2^RegWidth (0xFFFFFFFC + 4 = 0)
  - mispred = iExValid & ((taken != iExPredTaken) | (taken & (iExPredTarget != iExTarget)))
  - iExIsBranch and iExIsJump both high: treat as jump.
- FSM states IDLE, REDIRECT:
  - IDLE & mispred: at the next edge register oRedirPc = actual, set oRedirValid = 1, pulse oFlush = 1 for exactly that one cycle, increment oMispredCnt (wraps at 2^32), go to REDIRECT.
  - IDLE & no mispred: stay in IDLE; no redirect, no flush.
  - REDIRECT: oRedirValid and oRedirPc held stable; oExStall = 1. All iEx* inputs are ignored: no BHT update, no count, no new redirect.
  - REDIRECT & iRedirReady: handshake completes at that edge; next cycle oRedirValid = 0, oExStall = 0, state = IDLE.
  - Minimum redirect latency: mispredict cycle N, flush and redirect visible in cycle N+1, earliest return to IDLE in cycle N+2.
- oExStall is a registered output; it is 0 in IDLE.
- BHT:
  - Read: oFetchPredTaken = bht[iFetchPc[BhtIdxW+1:2]][1], combinational.
  - Update: on iExValid & iExIsBranch & ~iExIsJump in IDLE, the counter at iExPc index saturates upward if taken, downward otherwise (11 stays 11, 00 stays 00).
  - Jumps never update the BHT.
  - A read and a same-cycle update to the same index return the pre-update value (no bypass).
  - The update occurs on mispredicting branches as well.

Test Plan:
- Reset then iFetchPc = 0x100 -> oFetchPredTaken = 0, oMispredCnt = 0, oRedirValid = 0, bht[0] = 01.
- Branch at 0x200, iExBrTrue = 1, pred not-taken, target 0x240 -> next cycle oFlush = 1 for one cycle, oRedirValid = 1, oRedirPc = 0x240, oMispredCnt = 1; bht[idx 0] = 10; fetch lookup 0x200 now predicts 1.
- Same mispredict with iRedirReady low for 3 cycles -> oRedirValid/oExStall high and oRedirPc = 0x240 stable; an iExValid pulse during the wait causes no BHT or count change; ready high -> IDLE next cycle.
- Branch at 0xFFFFFFFC not taken, predicted taken -> oRedirPc = 0x00000000; branch at 0x300, taken, pred taken, iExPredTarget 0x310 vs iExTarget 0x320 -> redirect to 0x320.
- Four taken branches at 0x400 with correct predictions -> counter saturates at 11, no flush, no count change; JAL with correct prediction -> no BHT change.
- Assert iRst_n low in REDIRECT between edges -> outputs clear immediately; after release, oMispredCnt = 0 and all BHT counters = 01.
